// File: rtl/phase_sequencer_pkg.sv
// traffic_pkg: phase codes, index type and FSM states shared by the phase sequencer.
package traffic_pkg;
  localparam int NUM_PHASES = 7;
  typedef logic [2:0] phase_idx_t;
  typedef enum logic [1:0] {GREEN, YELLOW, ALLRED} fsm_e;
  localparam logic [3:0] CODE_A = 4'b0000;
  localparam logic [3:0] CODE_B = 4'b0001;
  localparam logic [3:0] CODE_C = 4'b0010;
  localparam logic [3:0] CODE_D = 4'b0100;
  localparam logic [3:0] CODE_E = 4'b1000;
  localparam logic [3:0] CODE_F = 4'b1111;
  localparam logic [3:0] CODE_G = 4'b1110;
  function automatic logic [3:0] code(input phase_idx_t idx);
    return idx == 3'd1 ? CODE_B :
           idx == 3'd2 ? CODE_C :
           idx == 3'd3 ? CODE_D :
           idx == 3'd4 ? CODE_E :
           idx == 3'd5 ? CODE_F :
           idx == 3'd6 ? CODE_G : CODE_A;
  endfunction
endpackage

// File: rtl/phase_sequencer_if.sv
// phase_sequencer_if: tick/request inputs and phase outputs of the sequencer.
interface phase_sequencer_if;
  import traffic_pkg::*;
  logic       tick;
  logic [6:0] req;
  logic [3:0] state;
  logic       yellow;
  logic       allred;
  phase_idx_t grant_idx;
  modport master(output tick, req, input state, yellow, allred, grant_idx);
  modport slave(input tick, req, output state, yellow, allred, grant_idx);
endinterface

// File: rtl/phase_sequencer_rr.sv
// rr_next_phase: first requesting phase after cur_idx_i, wrapping 6->0, excluding cur_idx_i.
module rr_next_phase
  import traffic_pkg::*;
(
  input  logic [6:0] req_i,
  input  phase_idx_t cur_idx_i,
  output phase_idx_t next_idx_o,
  output logic       found_o
);
  // scan farthest offset first so the nearest requester wins
  always_comb begin
    next_idx_o = cur_idx_i;
    found_o = 1'b0;
    for (int k = NUM_PHASES - 1; k >= 1; k--) begin
      if (req_i[(int'(cur_idx_i) + k) % NUM_PHASES]) begin
        next_idx_o = phase_idx_t'((int'(cur_idx_i) + k) % NUM_PHASES);
        found_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/phase_sequencer.sv
// phase_sequencer: round-robin green/yellow/all-red controller producing the phase code.
module phase_sequencer
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN = 5,
  parameter int MAX_GREEN = 20,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 1,
  parameter int TW        = 5
) (
  input logic clk,
  input logic rst_n,
  phase_sequencer_if.slave bus
);
  localparam logic [TW:0] MIN_N = (TW+1)'(MIN_GREEN);
  localparam logic [TW:0] MAX_N = (TW+1)'(MAX_GREEN);
  localparam logic [TW:0] YEL_N = (TW+1)'(YELLOW_T);
  localparam logic [TW:0] AR_N  = (TW+1)'(ALLRED_T);
  fsm_e          fsm_q, fsm_d;
  phase_idx_t    grant_q, grant_d, next_q, next_d, pick;
  logic [TW-1:0] dwell_q, dwell_d, n_sat;
  logic [TW:0]   n;
  logic [3:0]    state_q, state_d;
  logic          yellow_q, yellow_d, allred_q, allred_d, others_req, green_exit;
  rr_next_phase u_rr (
    .req_i      (bus.req),
    .cur_idx_i  (grant_q),
    .next_idx_o (pick),
    .found_o    (others_req)
  );
  assign n = (TW+1)'(dwell_q) + (TW+1)'(1);
  assign n_sat = n[TW] ? '1 : n[TW-1:0];
  assign green_exit = n >= MIN_N && others_req && (!bus.req[grant_q] || n >= MAX_N);
  // per-Tick state transitions; nothing moves without a Tick
  always_comb begin
    fsm_d = fsm_q;
    grant_d = grant_q;
    next_d = next_q;
    dwell_d = dwell_q;
    state_d = state_q;
    yellow_d = yellow_q;
    allred_d = allred_q;
    if (bus.tick) begin
      case (fsm_q)
        GREEN: begin
          dwell_d = green_exit ? '0 : n_sat;
          if (green_exit) begin
            fsm_d = YELLOW;
            yellow_d = 1'b1;
            next_d = pick;
          end
        end
        YELLOW: begin
          dwell_d = n == YEL_N ? '0 : n_sat;
          if (n == YEL_N) begin
            yellow_d = 1'b0;
            fsm_d = ALLRED_T > 0 ? ALLRED : GREEN;
            allred_d = ALLRED_T > 0;
            grant_d = ALLRED_T > 0 ? grant_q : next_q;
            state_d = ALLRED_T > 0 ? state_q : code(next_q);
          end
        end
        ALLRED: begin
          dwell_d = n == AR_N ? '0 : n_sat;
          if (n == AR_N) begin
            allred_d = 1'b0;
            fsm_d = GREEN;
            grant_d = next_q;
            state_d = code(next_q);
          end
        end
        default: begin
          fsm_d = GREEN;
          dwell_d = '0;
          yellow_d = 1'b0;
          allred_d = 1'b0;
        end
      endcase
    end
  end
  // state and registered outputs, async reset to phase A green
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q <= GREEN;
      grant_q <= '0;
      next_q <= '0;
      dwell_q <= '0;
      state_q <= CODE_A;
      yellow_q <= 1'b0;
      allred_q <= 1'b0;
    end else begin
      fsm_q <= fsm_d;
      grant_q <= grant_d;
      next_q <= next_d;
      dwell_q <= dwell_d;
      state_q <= state_d;
      yellow_q <= yellow_d;
      allred_q <= allred_d;
    end
  end
  assign bus.state = state_q;
  assign bus.yellow = yellow_q;
  assign bus.allred = allred_q;
  assign bus.grant_idx = grant_q;
endmodule

// File: tb/tb_phase_sequencer.sv
// tb_phase_sequencer: randomized scoreboard bench against a behavioural phase model.
module tb_phase_sequencer;
  typedef struct {int st; int y; int a; int g;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  int code_tab[7] = '{0, 1, 2, 4, 8, 15, 14};
  int m_mode, m_cnt, m_g, m_nxt;
  exp_t q[$];
  phase_sequencer_if b();
  phase_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(b.slave));
  always #5 clk = ~clk;
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic check_all(input string tag, input exp_t e);
    check({tag, ".state"}, int'(b.state), e.st);
    check({tag, ".yellow"}, int'(b.yellow), e.y);
    check({tag, ".allred"}, int'(b.allred), e.a);
    check({tag, ".grant"}, int'(b.grant_idx), e.g);
  endtask
  function automatic exp_t model_out();
    exp_t e;
    e.st = code_tab[m_g];
    e.y = m_mode == 1 ? 1 : 0;
    e.a = m_mode == 2 ? 1 : 0;
    e.g = m_g;
    return e;
  endfunction
  function automatic void model_reset();
    m_mode = 0; m_cnt = 0; m_g = 0; m_nxt = 0;
  endfunction
  // mode 0 = green, 1 = yellow, 2 = all-red; counts are Ticks spent in the mode
  function automatic void model_step(input bit t, input logic [6:0] r);
    int n;
    bit others;
    if (!t) return;
    n = m_cnt + 1;
    others = (r & ~(7'd1 << m_g)) != 0;
    if (m_mode == 0) begin
      if (n >= 5 && others && (!r[m_g] || n >= 20)) begin
        m_mode = 1; m_cnt = 0;
        for (int k = 6; k >= 1; k--) if (r[(m_g + k) % 7]) m_nxt = (m_g + k) % 7;
      end else m_cnt = n > 31 ? 31 : n;
    end else if (m_mode == 1) begin
      if (n == 3) begin m_mode = 2; m_cnt = 0; end else m_cnt = n;
    end else begin
      if (n == 1) begin m_mode = 0; m_cnt = 0; m_g = m_nxt; end else m_cnt = n;
    end
  endfunction
  task automatic cyc(input bit t, input logic [6:0] r);
    @(negedge clk);
    #2;
    b.tick = t;
    b.req = r;
    model_step(t, r);
    q.push_back(model_out());
  endtask
  task automatic do_reset(input bit t);
    exp_t e0;
    @(negedge clk);
    #2;
    b.tick = t;
    rst_n = 1'b0;
    model_reset();
    e0 = model_out();
    #1;
    check_all("rst_async", e0);
    @(posedge clk);
    #1;
    check_all("rst_held", e0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    b.tick = 1'b0;
  endtask
  // monitor: every cycle's expected outputs are checked one negedge later
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check_all("cyc", e);
      end
    end
  end
  initial begin
    logic [6:0] r;
    b.tick = 1'b0;
    b.req = '0;
    model_reset();
    do_reset(1'b0);
    for (int i = 0; i < 50; i++) cyc(1'b1, 7'b0000001);
    for (int i = 0; i < 10; i++) cyc(1'b1, 7'b0000011);
    do_reset(1'b0);
    for (int i = 0; i < 30; i++) cyc(1'b1, 7'b0000011);
    do_reset(1'b1);
    for (int i = 0; i < 2; i++) cyc(1'b1, 7'b0010001);
    for (int i = 0; i < 15; i++) cyc(1'b1, 7'b0010000);
    do_reset(1'b0);
    for (int i = 0; i < 7 * 24 + 6; i++) cyc(1'b1, 7'h7f);
    for (int i = 0; i < 200 && !(m_g == 6 && m_mode == 0); i++) cyc(1'b1, 7'h7f);
    for (int i = 0; i < 30; i++) cyc(1'b1, m_mode == 1 ? 7'b1000110 : 7'b1000100);
    r = 7'h7f;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 7) == 0) r = 7'($urandom);
      cyc($urandom_range(0, 3) != 0, r);
    end
    for (int i = 0; i < 40 && m_mode != 1; i++) cyc(1'b1, 7'h7f);
    cyc(1'b1, 7'h7f);
    do_reset(1'b1);
    for (int i = 0; i < 40 && m_mode != 1; i++) cyc(1'b1, 7'h7f);
    do_reset(1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b1, 7'h7f);
    @(negedge clk);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
- Sequential fairness controller that generates the 4-bit State code for the intersection; the State decoder consumes this code.
- Seven phases A..G (codes below); service is round-robin among approaches with cars waiting.
- Each green is bounded by a minimum and a maximum dwell, followed by yellow and all-red clearance intervals.
- Sits between the lane sensors / 1 Hz tick generator and the State decoder.

Parameters:
- MIN_GREEN, 5, minimum Ticks a phase stays green once entered.
- MAX_GREEN, 20, Ticks after which green is forced off if another phase is requesting (MIN_GREEN <= MAX_GREEN).
- YELLOW_T, 3, Ticks Yellow is asserted (>=1).
- ALLRED_T, 1, Ticks AllRed is asserted (0 = interval skipped).
- TW, 5, width of the dwell counter; the counter saturates at 2^TW-1.

Ports:
- Clock  in  1  system clock; all state updates on rising edge.
- Resetn  in  1  asynchronous, active-low reset.
- Tick  in  1  one-cycle timebase enable; all timing counts Tick cycles only.
- Req  in  7  level car-waiting sensors; bit i = phase i (0=A .. 6=G).
- State  out  4  registered phase code: A=0000, B=0001, C=0010, D=0100, E=1000, F=1111, G=1110.
- Yellow  out  1  registered; high during the YELLOW interval.
- AllRed  out  1  registered; high during the ALLRED interval.
- GrantIdx  out  3  registered index (0..6) of the current phase.

Behaviour:
- Reset (async assert, sync release is the integrator's job):
  - FSM=GREEN, GrantIdx=0, State=0000, Yellow=0, AllRed=0, DwellCnt=0, NextIdx=0.
- FSM states: GREEN, YELLOW, ALLRED. Nothing changes on cycles with Tick=0.
- On a Tick edge, let n = DwellCnt+1 (Ticks completed in the current state, including this one).
- GREEN:
  - OthersReq = OR of Req bits except GrantIdx.
  - Exit when n>=MIN_GREEN AND OthersReq AND (Req[GrantIdx]==0 OR n>=MAX_GREEN).
  - On exit: go to YELLOW, DwellCnt=0, Yellow=1, and latch NextIdx = first i with Req[i]=1, searching GrantIdx+1, GrantIdx+2 ... wrapping 6->0 and excluding GrantIdx.
  - Otherwise DwellCnt=n (saturating). The phase holds green indefinitely while no other phase requests.
- YELLOW:
  - Exit when n==YELLOW_T. Yellow=0.
  - If ALLRED_T>0: go to ALLRED, AllRed=1, DwellCnt=0.
  - Else: go to GREEN directly (same actions as ALLRED exit).
- ALLRED:
  - Exit when n==ALLRED_T: AllRed=0, GREEN, GrantIdx=NextIdx, State=code(NextIdx), DwellCnt=0.
- State and GrantIdx change only on entry to GREEN; they keep the old phase through YELLOW/ALLRED.
- NextIdx is fixed once latched; later changes to Req do not redirect the pending switch.
- Yellow and AllRed are never high together. Both are 0 in GREEN.
- State is always one of the 7 legal codes; the code mapping is a fixed ROM.
- Reset mid-interval: immediately returns to the reset values above; any pending NextIdx is discarded.
- Tick high on consecutive cycles: each cycle counts as one Tick.

Decomposition:
- Package traffic_pkg holds:
  - the 7 phase-code constants and the code(idx) lookup function;
  - NUM_PHASES=7;
  - the phase index type (3 bits);
  - the FSM state enum {GREEN, YELLOW, ALLRED}.
- Sub-module rr_next_phase: combinational round-robin picker. Inputs Req[6:0] and CurIdx; outputs NextIdx and Found. The top-level FSM, counters and output registers stay in phase_sequencer.

Test Plan:
- Reset then Req=0000001 for 50 Ticks -> State=0000 throughout, Yellow=AllRed=0.
- From reset, Req=0000011 held -> A green for exactly 20 Ticks (Req[0] high, MAX_GREEN) -> Yellow 3 Ticks -> AllRed 1 Tick -> State=0001, GrantIdx=1.
- From reset, Req[0] drops after 2 Ticks, Req[4]=1 -> switch is evaluated at Tick 5 (MIN_GREEN), not earlier -> after clearance State=1000.
- From G green (GrantIdx=6, State=1110), Req=1000100 -> wraps and selects C, State=0010. Req[1] raised during YELLOW does not change the selection.
- Req bits for A..G all high -> visiting order A,B,C,D,E,F,G,A with codes 0000,0001,0010,0100,1000,1111,1110,0000; each green lasts 20 Ticks.
- Resetn pulsed low mid-YELLOW, with and without Tick in the same cycle -> outputs go to reset values immediately, independent of Clock. First green after release is A.
